// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Multi-cycle sequencer for the MIPS-subset datapath (register
//            heap, SimpleALU, RAM, PC/next-PC mux). Runs a FETCH / DECODE /
//            EXEC / MEM / WB state machine so the ALU and RAM are shared
//            across instruction phases, drives every datapath strobe and
//            mux select, traps illegal instructions and counts retired
//            instructions.
// Ports    :
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active low
//   opcode      in   inst[31:26] from the instruction register
//   funct       in   inst[5:0] from the instruction register
//   ZF          in   ALU zero flag (used only by beq/bne in EXEC)
//   PCWrite     out  load PC from the PC_s-selected value
//   IRWrite     out  load instruction register from instruction memory
//   RegWrite    out  register heap write enable
//   MemWrite    out  data RAM write enable
//   ALU_OP      out  000 and,001 or,010 xor,011 nor,100 add,101 sub,
//                    110 slt,111 sllv
//   w_r_s       out  write-register select: 00 rd, 01 rt, 10 $31
//   w_r_data_s  out  write-data select: 00 ALU F, 01 Mem, 10 PC+4
//   imm_s       out  1 sign-extend immediate, 0 zero-extend
//   rt_imm_s    out  ALU B input: 1 immediate, 0 rt
//   PC_s        out  00 PC+4, 01 rs, 10 branch target, 11 jump target
//   state       out  current state code (debug)
//   halted      out  illegal instruction trapped
//   retire      out  one-cycle pulse in the final state of an instruction
//   inst_count  out  retired-instruction counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             ZF,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [2:0]       ALU_OP,
    output logic [1:0]       w_r_s,
    output logic [1:0]       w_r_data_s,
    output logic             imm_s,
    output logic             rt_imm_s,
    output logic [1:0]       PC_s,
    output logic [2:0]       state,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] inst_count
);

    // ------------------------------------------------------------------
    // State encoding (codes 5 and 6 are unused and recover to FETCH)
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_ALU_R   = 4'd1,
        C_ALU_I   = 4'd2,
        C_LW      = 4'd3,
        C_SW      = 4'd4,
        C_BEQ     = 4'd5,
        C_BNE     = 4'd6,
        C_J       = 4'd7,
        C_JAL     = 4'd8,
        C_JR      = 4'd9
    } cls_t;

    // Opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_XORI  = 6'h0E;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] c_FN_SLLV  = 6'h04;
    localparam logic [5:0] c_FN_JR    = 6'h08;
    localparam logic [5:0] c_FN_ADD   = 6'h20;
    localparam logic [5:0] c_FN_SUB   = 6'h22;
    localparam logic [5:0] c_FN_AND   = 6'h24;
    localparam logic [5:0] c_FN_OR    = 6'h25;
    localparam logic [5:0] c_FN_XOR   = 6'h26;
    localparam logic [5:0] c_FN_NOR   = 6'h27;
    localparam logic [5:0] c_FN_SLT   = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] c_ALU_AND  = 3'b000;
    localparam logic [2:0] c_ALU_OR   = 3'b001;
    localparam logic [2:0] c_ALU_XOR  = 3'b010;
    localparam logic [2:0] c_ALU_NOR  = 3'b011;
    localparam logic [2:0] c_ALU_ADD  = 3'b100;
    localparam logic [2:0] c_ALU_SUB  = 3'b101;
    localparam logic [2:0] c_ALU_SLT  = 3'b110;
    localparam logic [2:0] c_ALU_SLLV = 3'b111;

    // Mux select codes
    localparam logic [1:0] c_PC_PLUS4  = 2'b00;
    localparam logic [1:0] c_PC_RS     = 2'b01;
    localparam logic [1:0] c_PC_BRANCH = 2'b10;
    localparam logic [1:0] c_PC_JUMP   = 2'b11;
    localparam logic [1:0] c_WR_RD     = 2'b00;
    localparam logic [1:0] c_WR_RT     = 2'b01;
    localparam logic [1:0] c_WR_RA     = 2'b10;
    localparam logic [1:0] c_WD_ALU    = 2'b00;
    localparam logic [1:0] c_WD_MEM    = 2'b01;
    localparam logic [1:0] c_WD_PC4    = 2'b10;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state_q;
    state_t           w_state_d;
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    // ------------------------------------------------------------------
    // Decoder: purely a function of the (stable) instruction register
    // ------------------------------------------------------------------
    cls_t       w_cls;
    logic [2:0] w_dec_alu;
    logic       w_dec_sext;

    always_comb begin
        w_cls      = C_ILLEGAL;
        w_dec_alu  = c_ALU_AND;
        w_dec_sext = 1'b0;
        case (opcode)
            c_OP_RTYPE: begin
                w_cls = C_ALU_R;
                case (funct)
                    c_FN_ADD:  w_dec_alu = c_ALU_ADD;
                    c_FN_SUB:  w_dec_alu = c_ALU_SUB;
                    c_FN_AND:  w_dec_alu = c_ALU_AND;
                    c_FN_OR:   w_dec_alu = c_ALU_OR;
                    c_FN_XOR:  w_dec_alu = c_ALU_XOR;
                    c_FN_NOR:  w_dec_alu = c_ALU_NOR;
                    c_FN_SLT:  w_dec_alu = c_ALU_SLT;
                    c_FN_SLLV: w_dec_alu = c_ALU_SLLV;
                    c_FN_JR:   w_cls     = C_JR;
                    default:   w_cls     = C_ILLEGAL;
                endcase
            end
            c_OP_ADDI: begin
                w_cls      = C_ALU_I;
                w_dec_alu  = c_ALU_ADD;
                w_dec_sext = 1'b1;
            end
            c_OP_SLTI: begin
                w_cls      = C_ALU_I;
                w_dec_alu  = c_ALU_SLT;
                w_dec_sext = 1'b1;
            end
            c_OP_ANDI: begin
                w_cls     = C_ALU_I;
                w_dec_alu = c_ALU_AND;
            end
            c_OP_ORI: begin
                w_cls     = C_ALU_I;
                w_dec_alu = c_ALU_OR;
            end
            c_OP_XORI: begin
                w_cls     = C_ALU_I;
                w_dec_alu = c_ALU_XOR;
            end
            c_OP_LW:  w_cls = C_LW;
            c_OP_SW:  w_cls = C_SW;
            c_OP_BEQ: w_cls = C_BEQ;
            c_OP_BNE: w_cls = C_BNE;
            c_OP_J:   w_cls = C_J;
            c_OP_JAL: w_cls = C_JAL;
            default:  w_cls = C_ILLEGAL;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_mem_write;
    logic       w_retire;
    logic       w_halted;
    logic [2:0] w_alu_op;
    logic [1:0] w_wr_sel;
    logic [1:0] w_wd_sel;
    logic       w_imm_sel;
    logic       w_rt_imm_sel;
    logic [1:0] w_pc_sel;

    always_comb begin
        w_state_d    = r_state_q;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_retire     = 1'b0;
        w_halted     = 1'b0;
        w_alu_op     = c_ALU_AND;
        w_wr_sel     = c_WR_RD;
        w_wd_sel     = c_WD_ALU;
        w_imm_sel    = 1'b0;
        w_rt_imm_sel = 1'b0;
        w_pc_sel     = c_PC_PLUS4;

        case (r_state_q)
            S_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
                w_pc_sel   = c_PC_PLUS4;
                w_state_d  = S_DECODE;
            end

            S_DECODE: begin
                w_state_d = (w_cls == C_ILLEGAL) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                case (w_cls)
                    C_ALU_R: begin
                        w_alu_op  = w_dec_alu;
                        w_state_d = S_WB;
                    end
                    C_ALU_I: begin
                        w_alu_op     = w_dec_alu;
                        w_rt_imm_sel = 1'b1;
                        w_imm_sel    = w_dec_sext;
                        w_state_d    = S_WB;
                    end
                    C_LW: begin
                        w_alu_op     = c_ALU_ADD;
                        w_imm_sel    = 1'b1;
                        w_rt_imm_sel = 1'b1;
                        w_state_d    = S_MEM;
                    end
                    C_SW: begin
                        w_alu_op     = c_ALU_ADD;
                        w_imm_sel    = 1'b1;
                        w_rt_imm_sel = 1'b1;
                        w_mem_write  = 1'b1;
                        w_retire     = 1'b1;
                        w_state_d    = S_FETCH;
                    end
                    C_BEQ, C_BNE: begin
                        // The ALU subtracts rs-rt in this same cycle, so ZF
                        // is only meaningful here.
                        w_alu_op   = c_ALU_SUB;
                        w_imm_sel  = 1'b1;
                        w_pc_sel   = c_PC_BRANCH;
                        w_pc_write = (w_cls == C_BEQ) ? ZF : ~ZF;
                        w_retire   = 1'b1;
                        w_state_d  = S_FETCH;
                    end
                    C_J: begin
                        w_pc_sel   = c_PC_JUMP;
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_state_d  = S_FETCH;
                    end
                    C_JAL: begin
                        // PC+4 is still available from the PC register
                        // until this edge, so the link write happens here.
                        w_pc_sel    = c_PC_JUMP;
                        w_pc_write  = 1'b1;
                        w_reg_write = 1'b1;
                        w_wr_sel    = c_WR_RA;
                        w_wd_sel    = c_WD_PC4;
                        w_retire    = 1'b1;
                        w_state_d   = S_FETCH;
                    end
                    C_JR: begin
                        w_pc_sel   = c_PC_RS;
                        w_pc_write = 1'b1;
                        w_retire   = 1'b1;
                        w_state_d  = S_FETCH;
                    end
                    default: begin
                        // Instruction register changed under us: trap.
                        w_state_d = S_HALT;
                    end
                endcase
            end

            S_MEM: begin
                w_state_d = S_WB;
            end

            S_WB: begin
                case (w_cls)
                    C_ALU_R: begin
                        w_reg_write = 1'b1;
                        w_wr_sel    = c_WR_RD;
                        w_wd_sel    = c_WD_ALU;
                    end
                    C_ALU_I: begin
                        w_reg_write = 1'b1;
                        w_wr_sel    = c_WR_RT;
                        w_wd_sel    = c_WD_ALU;
                    end
                    C_LW: begin
                        w_reg_write = 1'b1;
                        w_wr_sel    = c_WR_RT;
                        w_wd_sel    = c_WD_MEM;
                    end
                    default: begin
                        w_reg_write = 1'b0;
                    end
                endcase
                w_retire  = 1'b1;
                w_state_d = S_FETCH;
            end

            S_HALT: begin
                w_halted  = 1'b1;
                w_state_d = S_HALT;
            end

            default: begin
                w_state_d = S_FETCH;
            end
        endcase
    end

    // Retire counter advances on every retiring edge and wraps naturally.
    always_comb begin
        w_count_d = r_count_q;
        if (w_retire) begin
            w_count_d = r_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= S_FETCH;
            r_count_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_count_q <= w_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: write strobes and retire are suppressed while reset is
    // asserted so nothing in the datapath changes during reset.
    // ------------------------------------------------------------------
    assign PCWrite    = w_pc_write  & rst;
    assign IRWrite    = w_ir_write  & rst;
    assign RegWrite   = w_reg_write & rst;
    assign MemWrite   = w_mem_write & rst;
    assign retire     = w_retire    & rst;
    assign ALU_OP     = w_alu_op;
    assign w_r_s      = w_wr_sel;
    assign w_r_data_s = w_wd_sel;
    assign imm_s      = w_imm_sel;
    assign rt_imm_s   = w_rt_imm_sel;
    assign PC_s       = w_pc_sel;
    assign state      = r_state_q;
    assign halted     = w_halted;
    assign inst_count = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Purpose  : Directed, table-driven bench for multicycle_controller. Each
//            record gives the inputs for one clock cycle and the outputs
//            expected in that cycle. A second instance with a 2-bit counter
//            watches counter wrap-around.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       ZF;

    logic        PCWrite, IRWrite, RegWrite, MemWrite;
    logic [2:0]  ALU_OP;
    logic [1:0]  w_r_s, w_r_data_s, PC_s;
    logic        imm_s, rt_imm_s, halted, retire;
    logic [2:0]  state;
    logic [31:0] inst_count;

    logic        n_pcw, n_irw, n_rw, n_mw, n_imm, n_rti, n_hlt, n_ret;
    logic [2:0]  n_alu, n_state;
    logic [1:0]  n_wrs, n_wrd, n_pcs;
    logic [1:0]  n_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .ZF(ZF),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .ALU_OP(ALU_OP), .w_r_s(w_r_s),
        .w_r_data_s(w_r_data_s), .imm_s(imm_s), .rt_imm_s(rt_imm_s),
        .PC_s(PC_s), .state(state), .halted(halted), .retire(retire),
        .inst_count(inst_count)
    );

    multicycle_controller #(.CNT_W(2)) dut_narrow (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .ZF(ZF),
        .PCWrite(n_pcw), .IRWrite(n_irw), .RegWrite(n_rw),
        .MemWrite(n_mw), .ALU_OP(n_alu), .w_r_s(n_wrs),
        .w_r_data_s(n_wrd), .imm_s(n_imm), .rt_imm_s(n_rti),
        .PC_s(n_pcs), .state(n_state), .halted(n_hlt), .retire(n_ret),
        .inst_count(n_count)
    );

    // exp = {state, PCWrite, IRWrite, RegWrite, MemWrite, ALU_OP, w_r_s,
    //        w_r_data_s, imm_s, rt_imm_s, PC_s, halted, retire}
    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zf;
        logic [19:0] exp;
        logic [31:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [5:0] op,
                                input logic [5:0] fn, input logic zf,
                                input logic [2:0] st, input logic [3:0] strb,
                                input logic [2:0] alu, input logic [1:0] wrs,
                                input logic [1:0] wrd, input logic imm,
                                input logic rti, input logic [1:0] pcs,
                                input logic hlt, input logic ret,
                                input int cnt);
        vec_t v;
        v.rst = r;
        v.op  = op;
        v.fn  = fn;
        v.zf  = zf;
        v.exp = {st, strb, alu, wrs, wrd, imm, rti, pcs, hlt, ret};
        v.cnt = 32'(cnt);
        return v;
    endfunction

    // FETCH cycle: IRWrite, PCWrite, PC_s=00
    function automatic vec_t vf(input logic [5:0] op, input logic [5:0] fn,
                                input int cnt);
        return mk(1'b1, op, fn, 1'b0, 3'd0, 4'b1100, 3'd0, 2'd0, 2'd0,
                  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, cnt);
    endfunction

    // DECODE cycle: no strobes, all selects 0
    function automatic vec_t vd(input logic [5:0] op, input logic [5:0] fn,
                                input int cnt);
        return mk(1'b1, op, fn, 1'b0, 3'd1, 4'b0000, 3'd0, 2'd0, 2'd0,
                  1'b0, 1'b0, 2'd0, 1'b0, 1'b0, cnt);
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        logic [19:0] act;
        @(negedge clk);
        rst    = v.rst;
        opcode = v.op;
        funct  = v.fn;
        ZF     = v.zf;
        #1;
        act = {state, PCWrite, IRWrite, RegWrite, MemWrite, ALU_OP, w_r_s,
               w_r_data_s, imm_s, rt_imm_s, PC_s, halted, retire};
        checks++;
        if (act !== v.exp) begin
            errors++;
            $display("FAIL %s outputs actual=%05h required=%05h",
                     name, act, v.exp);
        end
        checks++;
        if (inst_count !== v.cnt) begin
            errors++;
            $display("FAIL %s inst_count actual=%0d required=%0d",
                     name, inst_count, v.cnt);
        end
        checks++;
        if (n_count !== v.cnt[1:0]) begin
            errors++;
            $display("FAIL %s narrow_count actual=%0d required=%0d",
                     name, n_count, v.cnt[1:0]);
        end
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b0;
        opcode = 6'h00;
        funct  = 6'h00;
        ZF     = 1'b0;
        @(posedge clk);
        @(posedge clk);

        // Still in reset: FETCH state, strobes forced low
        tbl.push_back(mk(0, 6'h00, 6'h00, 0, 3'd0, 4'b0000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        // add
        tbl.push_back(vf(6'h00, 6'h20, 0));
        tbl.push_back(vd(6'h00, 6'h20, 0));
        tbl.push_back(mk(1, 6'h00, 6'h20, 0, 3'd2, 4'b0000, 3'd4, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 0));
        tbl.push_back(mk(1, 6'h00, 6'h20, 0, 3'd4, 4'b0010, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 1, 0));
        // lw
        tbl.push_back(vf(6'h23, 6'h00, 1));
        tbl.push_back(vd(6'h23, 6'h00, 1));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 3'd2, 4'b0000, 3'd4, 2'd0, 2'd0, 1, 1, 2'd0, 0, 0, 1));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 3'd3, 4'b0000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 1));
        tbl.push_back(mk(1, 6'h23, 6'h00, 0, 3'd4, 4'b0010, 3'd0, 2'd1, 2'd1, 0, 0, 2'd0, 0, 1, 1));
        // sw
        tbl.push_back(vf(6'h2B, 6'h00, 2));
        tbl.push_back(vd(6'h2B, 6'h00, 2));
        tbl.push_back(mk(1, 6'h2B, 6'h00, 0, 3'd2, 4'b0001, 3'd4, 2'd0, 2'd0, 1, 1, 2'd0, 0, 1, 2));
        // beq taken (ZF=1)
        tbl.push_back(vf(6'h04, 6'h00, 3));
        tbl.push_back(vd(6'h04, 6'h00, 3));
        tbl.push_back(mk(1, 6'h04, 6'h00, 1, 3'd2, 4'b1000, 3'd5, 2'd0, 2'd0, 1, 0, 2'd2, 0, 1, 3));
        // beq not taken
        tbl.push_back(vf(6'h04, 6'h00, 4));
        tbl.push_back(vd(6'h04, 6'h00, 4));
        tbl.push_back(mk(1, 6'h04, 6'h00, 0, 3'd2, 4'b0000, 3'd5, 2'd0, 2'd0, 1, 0, 2'd2, 0, 1, 4));
        // bne with ZF=1: not taken
        tbl.push_back(vf(6'h05, 6'h00, 5));
        tbl.push_back(vd(6'h05, 6'h00, 5));
        tbl.push_back(mk(1, 6'h05, 6'h00, 1, 3'd2, 4'b0000, 3'd5, 2'd0, 2'd0, 1, 0, 2'd2, 0, 1, 5));
        // bne with ZF=0: taken
        tbl.push_back(vf(6'h05, 6'h00, 6));
        tbl.push_back(vd(6'h05, 6'h00, 6));
        tbl.push_back(mk(1, 6'h05, 6'h00, 0, 3'd2, 4'b1000, 3'd5, 2'd0, 2'd0, 1, 0, 2'd2, 0, 1, 6));
        // jal
        tbl.push_back(vf(6'h03, 6'h00, 7));
        tbl.push_back(vd(6'h03, 6'h00, 7));
        tbl.push_back(mk(1, 6'h03, 6'h00, 0, 3'd2, 4'b1010, 3'd0, 2'd2, 2'd2, 0, 0, 2'd3, 0, 1, 7));
        // j
        tbl.push_back(vf(6'h02, 6'h00, 8));
        tbl.push_back(vd(6'h02, 6'h00, 8));
        tbl.push_back(mk(1, 6'h02, 6'h00, 0, 3'd2, 4'b1000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd3, 0, 1, 8));
        // jr
        tbl.push_back(vf(6'h00, 6'h08, 9));
        tbl.push_back(vd(6'h00, 6'h08, 9));
        tbl.push_back(mk(1, 6'h00, 6'h08, 0, 3'd2, 4'b1000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd1, 0, 1, 9));
        // ori (zero-extend)
        tbl.push_back(vf(6'h0D, 6'h00, 10));
        tbl.push_back(vd(6'h0D, 6'h00, 10));
        tbl.push_back(mk(1, 6'h0D, 6'h00, 0, 3'd2, 4'b0000, 3'd1, 2'd0, 2'd0, 0, 1, 2'd0, 0, 0, 10));
        tbl.push_back(mk(1, 6'h0D, 6'h00, 0, 3'd4, 4'b0010, 3'd0, 2'd1, 2'd0, 0, 0, 2'd0, 0, 1, 10));
        // xor (R-type)
        tbl.push_back(vf(6'h00, 6'h26, 11));
        tbl.push_back(vd(6'h00, 6'h26, 11));
        tbl.push_back(mk(1, 6'h00, 6'h26, 0, 3'd2, 4'b0000, 3'd2, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 11));
        tbl.push_back(mk(1, 6'h00, 6'h26, 0, 3'd4, 4'b0010, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 1, 11));
        // slti (sign-extend)
        tbl.push_back(vf(6'h0A, 6'h00, 12));
        tbl.push_back(vd(6'h0A, 6'h00, 12));
        tbl.push_back(mk(1, 6'h0A, 6'h00, 0, 3'd2, 4'b0000, 3'd6, 2'd0, 2'd0, 1, 1, 2'd0, 0, 0, 12));
        tbl.push_back(mk(1, 6'h0A, 6'h00, 0, 3'd4, 4'b0010, 3'd0, 2'd1, 2'd0, 0, 0, 2'd0, 0, 1, 12));
        // sllv
        tbl.push_back(vf(6'h00, 6'h04, 13));
        tbl.push_back(vd(6'h00, 6'h04, 13));
        tbl.push_back(mk(1, 6'h00, 6'h04, 0, 3'd2, 4'b0000, 3'd7, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 13));
        tbl.push_back(mk(1, 6'h00, 6'h04, 0, 3'd4, 4'b0010, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 1, 13));
        // Illegal opcode 3F: DECODE -> HALT, sticky for 10 cycles (ZF toggling)
        tbl.push_back(vf(6'h3F, 6'h00, 14));
        tbl.push_back(vd(6'h3F, 6'h00, 14));
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk(1, 6'h3F, 6'h00, k[0], 3'd7, 4'b0000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 1, 0, 14));
        end
        // One reset cycle while halted, then FETCH with halted clear
        tbl.push_back(mk(0, 6'h3F, 6'h00, 0, 3'd7, 4'b0000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 1, 0, 14));
        tbl.push_back(vf(6'h00, 6'h21, 0));
        // Unsupported R-type funct 21 also traps
        tbl.push_back(vd(6'h00, 6'h21, 0));
        tbl.push_back(mk(1, 6'h00, 6'h21, 0, 3'd7, 4'b0000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Leave HALT through reset, then reset in the middle of a lw (MEM)
        run_vec(mk(0, 6'h00, 6'h21, 0, 3'd7, 4'b0000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 1, 0, 0), "lwrst_a");
        run_vec(vf(6'h23, 6'h00, 0), "lwrst_fetch");
        run_vec(vd(6'h23, 6'h00, 0), "lwrst_decode");
        run_vec(mk(1, 6'h23, 6'h00, 0, 3'd2, 4'b0000, 3'd4, 2'd0, 2'd0, 1, 1, 2'd0, 0, 0, 0), "lwrst_exec");
        run_vec(mk(0, 6'h23, 6'h00, 0, 3'd3, 4'b0000, 3'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0, 0), "lwrst_mem");
        run_vec(vf(6'h23, 6'h00, 0), "lwrst_refetch");
        run_vec(vd(6'h23, 6'h00, 0), "lwrst_redecode");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the MIPS-subset datapath: register heap, SimpleALU, RAM and PC/next-PC mux.
- Replaces the single-cycle combinational Controller so the datapath can share the ALU and RAM across instruction phases.
- Decodes opcode/funct from the datapath's instruction register, which is held stable by IRWrite, and runs a FETCH/DECODE/EXEC/MEM/WB state machine.
- Drives every datapath strobe and mux select, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- opcode  in  6  inst[31:26] from the instruction register.
- funct  in  6  inst[5:0] from the instruction register.
- ZF  in  1  ALU zero flag.
- PCWrite  out  1  load PC from the PC_s-selected value.
- IRWrite  out  1  load the instruction register from instruction memory.
- RegWrite  out  1  register heap write enable.
- MemWrite  out  1  data RAM write enable.
- ALU_OP  out  3  000 and, 001 or, 010 xor, 011 nor, 100 add, 101 sub, 110 slt, 111 sllv.
- w_r_s  out  2  write-register select: 00 rd, 01 rt, 10 $31.
- w_r_data_s  out  2  write-data select: 00 ALU F, 01 Mem, 10 PC+4.
- imm_s  out  1  1 = sign-extend imm, 0 = zero-extend.
- rt_imm_s  out  1  ALU B input: 1 = immediate, 0 = rt.
- PC_s  out  2  00 PC+4, 01 rs (jr), 10 branch target, 11 jump target.
- state  out  3  current state, for debug.
- halted  out  1  illegal instruction trapped.
- retire  out  1  one-cycle pulse in the final state of each instruction.
- inst_count  out  CNT_W  number of retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. Codes 5 and 6 go to FETCH on the next edge.
- Reset: rst sampled low at a rising edge gives state=FETCH, halted=0, inst_count=0.
  - While rst is low, PCWrite, IRWrite, RegWrite, MemWrite and retire are forced to 0.
  - Reset wins over every other event, including mid-instruction.
- Outputs are combinational from state, opcode, funct and ZF. Any select not listed below is 0.
- FETCH: IRWrite=1, PCWrite=1, PC_s=00. Next state DECODE.
- DECODE: legal instruction goes to EXEC; illegal goes to HALT with no strobes.
- Supported instructions:
  - R-type (opcode 0), by funct: 20 add, 22 sub, 24 and, 25 or, 26 xor, 27 nor, 2A slt, 04 sllv, 08 jr.
  - I-type, by opcode (hex): 08 addi (sign-extend), 0A slti (sign-extend), 0C andi, 0D ori, 0E xori (zero-extend), 23 lw, 2B sw, 04 beq, 05 bne.
  - J-type: 02 j, 03 jal.
- EXEC, ALU group: ALU_OP per instruction; rt_imm_s=1 for I-type. Next state WB.
- EXEC, lw/sw: ALU_OP=add, imm_s=1, rt_imm_s=1.
  - sw: MemWrite=1, retire; next state FETCH.
  - lw: next state MEM.
- EXEC, beq/bne: ALU_OP=sub, rt_imm_s=0, imm_s=1, PC_s=10.
  - PCWrite = ZF for beq, ~ZF for bne.
  - retire; next state FETCH.
- EXEC, j: PC_s=11, PCWrite=1, retire; next state FETCH.
- EXEC, jal: PC_s=11, PCWrite=1, RegWrite=1, w_r_s=10, w_r_data_s=10, retire; next state FETCH.
- EXEC, jr: PC_s=01, PCWrite=1, retire; next state FETCH.
- MEM (lw only): RAM read; no strobes. Next state WB.
- WB:
  - ALU group: RegWrite=1, w_r_s=00 for R-type or 01 for I-type, w_r_data_s=00.
  - lw: RegWrite=1, w_r_s=01, w_r_data_s=01.
  - retire; next state FETCH.
- Latency in cycles: R-type/ALU-I 4; lw 5; sw 3; beq/bne/j/jal/jr 3.
- inst_count increments on each edge where retire=1, and wraps at 2^CNT_W-1 to 0.
- HALT: halted=1, all strobes 0, the state is sticky. Only reset leaves HALT.
- ZF is sampled only in EXEC of beq/bne.

Test Plan:
- Reset: hold rst=0 for 2 cycles, then release. Expect state=0 and inst_count=0. The next cycle shows IRWrite=1, PCWrite=1, PC_s=00, then state=1.
- add (op 00, funct 20): states 0,1,2,4,0. ALU_OP=100 in EXEC. RegWrite=1 with w_r_s=00 only in WB. retire pulses once and inst_count goes to 1.
- lw (op 23) then sw (op 2B):
  - lw: 5 cycles, WB with w_r_data_s=01 and w_r_s=01.
  - sw: 3 cycles, MemWrite=1 only in EXEC, RegWrite never asserted.
- beq (op 04):
  - ZF=1: PCWrite=1 with PC_s=10 in EXEC.
  - ZF=0: PCWrite=0.
  - bne (op 05) gives the inverse.
  - Each case takes 3 cycles.
- jal (op 03): EXEC has PCWrite=1, PC_s=11, RegWrite=1, w_r_s=10, w_r_data_s=10.
- Illegal opcode 3F: DECODE→HALT, halted=1 and strobes 0 for 10 cycles. rst=0 for one cycle gives FETCH, halted=0.
- Separately, assert rst mid-lw (in the MEM state): the next state is FETCH with no RegWrite.
